// File: rtl/particle_bank.sv
// Six-entry particle store (position/velocity) with a written-mask and a
// ready/valid readout sweep that presents entries 0..5 once per start.
module particle_bank #(
  parameter int DATA_W = 16
) (
  input  logic              clk_P,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0] wr_v,
  input  logic              start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_v,
  output logic              full,
  output logic              sweep_done,
  output logic              wr_err
);

  localparam int          NUM_ENT = 6;
  localparam logic [2:0]  LAST    = 3'd5;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem_x [NUM_ENT];
  logic [DATA_W-1:0] mem_v [NUM_ENT];
  logic [5:0]        mask, mask_nxt;
  logic              wr_ok;
  logic [2:0]        idx, idx_nxt, idx_inc;
  logic              valid_nxt, done_nxt;
  logic [2:0]        addr_nxt;
  logic [DATA_W-1:0] x_nxt, v_nxt;

  assign wr_ok    = wr_en && (wr_addr < 3'd6);
  assign mask_nxt = mask | (wr_ok ? (6'b000001 << wr_addr) : 6'b000000);
  assign idx_inc  = idx + 3'd1;

  // Storage is data-only and deliberately left out of reset.
  always_ff @(posedge clk_P) begin
    if (wr_ok) begin
      mem_x[wr_addr] <= wr_x;
      mem_v[wr_addr] <= wr_v;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    valid_nxt = rd_valid;
    addr_nxt  = rd_addr;
    x_nxt     = rd_x;
    v_nxt     = rd_v;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && full) begin
          state_nxt = READ;
          idx_nxt   = 3'd0;
          valid_nxt = 1'b1;
          addr_nxt  = 3'd0;
          x_nxt     = mem_x[0];
          v_nxt     = mem_v[0];
        end
      end
      READ: begin
        if (rd_valid && rd_ready) begin
          if (idx < LAST) begin
            idx_nxt  = idx_inc;
            addr_nxt = idx_inc;
            x_nxt    = mem_x[idx_inc];
            v_nxt    = mem_v[idx_inc];
          end else begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // full tracks the mask including this edge's write, so it rises with the sixth entry.
  always_ff @(posedge clk_P or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      mask       <= 6'd0;
      full       <= 1'b0;
      wr_err     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_addr    <= 3'd0;
      rd_x       <= '0;
      rd_v       <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      mask       <= mask_nxt;
      full       <= &mask_nxt;
      if (wr_en && !wr_ok)
        wr_err   <= 1'b1;
      rd_valid   <= valid_nxt;
      rd_addr    <= addr_nxt;
      rd_x       <= x_nxt;
      rd_v       <= v_nxt;
      sweep_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_particle_bank.sv
// Directed-plus-random bench for particle_bank against an array-based reference model.
module tb_particle_bank;

  logic        clk_P = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_x, wr_v;
  logic        start;
  logic        rd_ready;
  logic        rd_valid;
  logic [2:0]  rd_addr;
  logic [15:0] rd_x, rd_v;
  logic        full, sweep_done, wr_err;

  int checks = 0;
  int errors = 0;

  // Reference model: entry contents, which entries were written, sticky error.
  logic [15:0] ref_x [6];
  logic [15:0] ref_v [6];
  bit          ref_written [6];
  bit          ref_err;

  particle_bank dut (
    .clk_P(clk_P), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_v(wr_v), .start(start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_x(rd_x), .rd_v(rd_v),
    .full(full), .sweep_done(sweep_done), .wr_err(wr_err)
  );

  always #5 clk_P = ~clk_P;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit model_full();
    for (int i = 0; i < 6; i++) if (!ref_written[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_P);
    #1;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [15:0] x, input logic [15:0] v);
    if (a < 6) begin
      ref_x[a] = x;
      ref_v[a] = v;
      ref_written[a] = 1'b1;
    end else begin
      ref_err = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) ref_written[i] = 1'b0;
    ref_err = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] x, input logic [15:0] v);
    wr_en = 1'b1; wr_addr = a; wr_x = x; wr_v = v;
    step();
    wr_en = 1'b0;
    model_write(a, x, v);
    chk("full_after_wr", full, model_full());
    chk("wr_err_after_wr", wr_err, ref_err);
  endtask

  task automatic start_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_start_valid", rd_valid, 1'b0);
    step();
    chk("ign_start_valid2", rd_valid, 1'b0);
    chk("ign_start_done", sweep_done, 1'b0);
  endtask

  // One readout sweep; optional stall (with start and same-entry write), mid-sweep write, abort.
  task automatic sweep(input int stall_at, input int stall_n, input bit stall_wr,
                       input int wr_at, input logic [2:0] wr_a, input logic [15:0] wr_d,
                       input int abort_at, input bit start_in_done);
    logic [15:0] sx, sv, nx, nv;
    rd_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("sw_valid", rd_valid, 1'b1);
      chk("sw_addr", rd_addr, i);
      chk("sw_x", rd_x, ref_x[i]);
      chk("sw_v", rd_v, ref_v[i]);
      sx = ref_x[i];
      sv = ref_v[i];
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_valid", rd_valid, 1'b0);
        chk("abort_addr", rd_addr, 0);
        chk("abort_x", rd_x, 0);
        chk("abort_v", rd_v, 0);
        chk("abort_full", full, 1'b0);
        chk("abort_done", sweep_done, 1'b0);
        chk("abort_err", wr_err, 1'b0);
        reset = 1'b0;
        model_reset();
        step();
        chk("abort_no_done", sweep_done, 1'b0);
        return;
      end
      if (i == stall_at) begin
        rd_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          nx = 16'($urandom);
          nv = 16'($urandom);
          if (k == 0 && stall_wr) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_x = nx; wr_v = nv;
          end
          start = 1'b1;
          step();
          start = 1'b0;
          if (k == 0 && stall_wr) begin
            wr_en = 1'b0;
            model_write(3'(i), nx, nv);
          end
          chk("stall_valid", rd_valid, 1'b1);
          chk("stall_addr", rd_addr, i);
          chk("stall_x", rd_x, sx);
          chk("stall_v", rd_v, sv);
        end
        rd_ready = 1'b1;
      end
      if (i == wr_at) begin
        nv = 16'($urandom);
        wr_en = 1'b1; wr_addr = wr_a; wr_x = wr_d; wr_v = nv;
        step();
        wr_en = 1'b0;
        model_write(wr_a, wr_d, nv);
      end else begin
        step();
      end
    end
    chk("end_valid", rd_valid, 1'b0);
    chk("end_done", sweep_done, 1'b1);
    if (start_in_done) start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done", sweep_done, 1'b0);
    chk("post_valid", rd_valid, 1'b0);
    if (start_in_done) begin
      step();
      chk("done_start_ign", rd_valid, 1'b0);
    end
  endtask

  initial begin
    int sa, sn, wa;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_v = '0;
    start = 1'b0; rd_ready = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_x", rd_x, 0);
    chk("rst_v", rd_v, 0);
    chk("rst_full", full, 1'b0);
    chk("rst_done", sweep_done, 1'b0);
    chk("rst_err", wr_err, 1'b0);
    reset = 1'b0;
    step();

    // Five entries: start must be ignored while not full.
    for (int i = 0; i < 5; i++) wr(3'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
    start_ignored();
    wr(3'd5, 16'h1005, 16'h2005);
    chk("full_six", full, 1'b1);
    sweep(-1, 0, 1'b0, -1, 3'd0, 16'h0, -1, 1'b0);

    // Out-of-range write: sticky error, nothing stored.
    wr(3'd6, 16'hFFFF, 16'hFFFF);
    chk("oob_err", wr_err, 1'b1);
    chk("oob_full", full, 1'b1);
    wr(3'd7, 16'hEEEE, 16'hEEEE);
    sweep(2, 3, 1'b0, -1, 3'd0, 16'h0, -1, 1'b1);

    // Mid-sweep write to a not-yet-presented entry, and a rewrite of the stalled entry.
    sweep(3, 2, 1'b1, 1, 3'd4, 16'hABCD, -1, 1'b0);
    chk("req38_model", ref_x[4], 16'hABCD);
    sweep(-1, 0, 1'b0, -1, 3'd0, 16'h0, -1, 1'b0);

    // Reset mid-sweep, then start ignored until six fresh writes.
    sweep(-1, 0, 1'b0, -1, 3'd0, 16'h0, 3, 1'b0);
    start_ignored();
    for (int i = 0; i < 5; i++) wr(3'(i), 16'($urandom), 16'($urandom));
    start_ignored();
    start = 1'b1;
    wr(3'd5, 16'($urandom), 16'($urandom));
    start = 1'b0;
    chk("same_cycle_valid", rd_valid, 1'b0);
    step();
    chk("same_cycle_valid2", rd_valid, 1'b0);
    sweep(-1, 0, 1'b0, -1, 3'd0, 16'h0, -1, 1'b0);

    // Randomized sweeps with random rewrites, stalls and mid-sweep writes.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 3; k++) wr(3'($urandom_range(7, 0)), 16'($urandom), 16'($urandom));
      sa = int'($urandom_range(5, 0));
      sn = int'($urandom_range(4, 1));
      wa = int'($urandom_range(3, 0));
      sweep(sa, sn, 1'($urandom), wa, 3'(wa + int'($urandom_range(5 - wa, 2))),
            16'($urandom), -1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
